// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the sequencer.
// master = stage side (requests out), slave = pipe_ctrl (control out).
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_mem;
  logic              div_start;
  logic              exc_valid;
  logic              exc_is_eret;
  logic [ADDR_W-1:0] epc_i;
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              div_busy;
  logic              div_done;
  logic [31:0]       stall_cycles;

  modport master (
    output stallreq_if, stallreq_id, stallreq_mem,
    output div_start, exc_valid, exc_is_eret, epc_i,
    input  stall, flush, new_pc,
    input  div_busy, div_done, stall_cycles
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_mem,
    input  div_start, exc_valid, exc_is_eret, epc_i,
    output stall, flush, new_pc,
    output div_busy, div_done, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, holds EX for divides,
// flushes/redirects on exception or eret, counts front-end stalls.
// Ports: clk, rst (sync, active-high), bus (pipe_ctrl_if.slave):
//   in : stallreq_if/id/mem, div_start, exc_valid, exc_is_eret, epc_i
//   out: stall[5:0], flush, new_pc, div_busy, div_done, stall_cycles
module pipe_ctrl #(
  parameter int                DIV_CYCLES = 32,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_CYCLES - 1);

  typedef enum logic {
    RUN,
    DIV
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [31:0]       stall_cnt;

  logic              accept;
  logic              div_hold;
  logic              ex_hold;
  logic [5:0]        stall_v;
  logic              flush_v;
  logic [ADDR_W-1:0] pc_v;
  logic              done_v;

  // A divide issued while MEM stalls is not taken;
  // EX re-presents it on a later cycle.
  assign accept = (state == RUN) & bus.div_start
                & ~bus.exc_valid & ~bus.stallreq_mem;

  assign div_hold = (state == DIV) & (cnt != '0);
  assign ex_hold  = accept | div_hold;

  assign done_v = (state == DIV) & (cnt == '0)
                & ~bus.stallreq_mem & ~bus.exc_valid;

  always_comb begin
    stall_v = 6'b000000;
    flush_v = 1'b0;
    pc_v    = '0;
    if (bus.exc_valid) begin
      flush_v = 1'b1;
      pc_v    = bus.exc_is_eret ? bus.epc_i : EXC_VECTOR;
    end else if (bus.stallreq_mem) begin
      stall_v = 6'b011111;
    end else if (ex_hold) begin
      stall_v = 6'b001111;
    end else if (bus.stallreq_id) begin
      stall_v = 6'b000111;
    end else if (bus.stallreq_if) begin
      stall_v = 6'b000011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall_v[1]) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bus.exc_valid) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        unique case (state)
          RUN: begin
            if (accept) begin
              state <= DIV;
              cnt   <= CNT_INIT;
            end
          end
          DIV: begin
            if (!bus.stallreq_mem) begin
              if (cnt != '0) begin
                cnt <= cnt - CW'(1);
              end else begin
                state <= RUN;
              end
            end
          end
          default: begin
            state <= RUN;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.stall        = rst ? 6'b000000 : stall_v;
  assign bus.flush        = ~rst & flush_v;
  assign bus.new_pc       = rst ? '0 : pc_v;
  assign bus.div_busy     = ~rst & (state == DIV);
  assign bus.div_done     = ~rst & done_v;
  assign bus.stall_cycles = rst ? 32'd0 : stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with DIV_CYCLES=4.
// Each vector carries hand-computed expectations; a model checks every cycle.
module tb_pipe_ctrl;

  localparam int          DC  = 4;
  localparam logic [31:0] VEC = 32'hBFC00380;

  localparam logic [6:0] IFR  = 7'd1;
  localparam logic [6:0] ID   = 7'd2;
  localparam logic [6:0] MEM  = 7'd4;
  localparam logic [6:0] DS   = 7'd8;
  localparam logic [6:0] EXC  = 7'd16;
  localparam logic [6:0] ERET = 7'd32;
  localparam logic [6:0] RST  = 7'd64;

  logic clk;
  logic rst;

  pipe_ctrl_if #(.ADDR_W(32)) bus ();

  pipe_ctrl #(
    .DIV_CYCLES(DC),
    .ADDR_W(32),
    .EXC_VECTOR(VEC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // literal expectations for the current vector, -1 = don't care
  int     l_stall = -1;
  int     l_done  = -1;
  int     l_busy  = -1;
  int     l_flush = -1;
  longint l_pc    = -1;
  longint l_sc    = -1;
  logic   wrap_load = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, got, exp);
    end
  endtask

  // model: a divide owes a number of EX-hold cycles after its issue
  logic        m_busy = 1'b0;
  int          m_owed = 0;
  logic [31:0] m_cnt  = '0;

  always @(negedge clk) begin
    logic        acc;
    logic        hold;
    int          depth;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_sc;

    if (l_stall >= 0) chk("lit_stall", 64'(bus.stall), 64'(l_stall));
    if (l_done >= 0)  chk("lit_done", 64'(bus.div_done), 64'(l_done));
    if (l_busy >= 0)  chk("lit_busy", 64'(bus.div_busy), 64'(l_busy));
    if (l_flush >= 0) chk("lit_flush", 64'(bus.flush), 64'(l_flush));
    if (l_pc >= 0)    chk("lit_pc", 64'(bus.new_pc), 64'(l_pc));
    if (l_sc >= 0)    chk("lit_sc", 64'(bus.stall_cycles), 64'(l_sc));

    if (rst) begin
      e_stall = '0;
      e_flush = 1'b0;
      e_pc    = '0;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      e_sc    = '0;
      m_busy  = 1'b0;
      m_owed  = 0;
      m_cnt   = '0;
    end else begin
      if (wrap_load) m_cnt = 32'hFFFF_FFFF;
      acc  = !m_busy && bus.div_start && !bus.exc_valid
             && !bus.stallreq_mem;
      hold = acc || (m_busy && m_owed > 0);
      if (bus.exc_valid)         depth = 0;
      else if (bus.stallreq_mem) depth = 5;
      else if (hold)             depth = 4;
      else if (bus.stallreq_id)  depth = 3;
      else if (bus.stallreq_if)  depth = 2;
      else                       depth = 0;
      e_stall = 6'((1 << depth) - 1);
      e_flush = bus.exc_valid;
      e_pc    = !bus.exc_valid ? 32'd0
              : bus.exc_is_eret ? bus.epc_i : VEC;
      e_busy  = m_busy;
      e_done  = m_busy && m_owed == 0 && !bus.stallreq_mem
                && !bus.exc_valid;
      e_sc    = m_cnt;
      if (e_stall[1]) m_cnt = m_cnt + 32'd1;
      if (bus.exc_valid) begin
        m_busy = 1'b0;
        m_owed = 0;
      end else if (acc) begin
        m_busy = 1'b1;
        m_owed = DC - 1;
      end else if (m_busy && !bus.stallreq_mem) begin
        if (m_owed > 0) m_owed--;
        else m_busy = 1'b0;
      end
    end

    chk("stall", 64'(bus.stall), 64'(e_stall));
    chk("flush", 64'(bus.flush), 64'(e_flush));
    chk("new_pc", 64'(bus.new_pc), 64'(e_pc));
    chk("div_busy", 64'(bus.div_busy), 64'(e_busy));
    chk("div_done", 64'(bus.div_done), 64'(e_done));
    chk("stall_cycles", 64'(bus.stall_cycles), 64'(e_sc));
  end

  task automatic vec(input logic [6:0] r, input logic [31:0] epc,
                     input int xs, input int xd, input int xb,
                     input int xf, input longint xpc, input longint xsc);
    bus.stallreq_if  = r[0];
    bus.stallreq_id  = r[1];
    bus.stallreq_mem = r[2];
    bus.div_start    = r[3];
    bus.exc_valid    = r[4];
    bus.exc_is_eret  = r[5];
    rst              = r[6];
    bus.epc_i        = epc;
    l_stall = xs;
    l_done  = xd;
    l_busy  = xb;
    l_flush = xf;
    l_pc    = xpc;
    l_sc    = xsc;
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] ALL = IFR | ID | MEM | DS | EXC | ERET;

  initial begin
    // reset with every request high
    vec(RST | ALL, 32'h1111_2222, 0, 0, 0, 0, 0, 0);
    vec(RST | ALL, 32'h1111_2222, 0, 0, 0, 0, 0, 0);
    vec(IFR, 0, 3, 0, 0, 0, 0, 0);
    vec(IFR, 0, 3, -1, -1, -1, -1, 1);
    vec(0, 0, 0, -1, -1, -1, -1, 2);

    // priority ladder
    vec(IFR, 0, 3, -1, -1, 0, 0, -1);
    vec(IFR | ID, 0, 7, -1, -1, 0, -1, -1);
    vec(IFR | ID | MEM, 0, 31, -1, -1, 0, -1, -1);
    vec(IFR | ID | MEM | EXC, 32'h8000_0000, 0, -1, -1, 1,
        64'hBFC0_0380, -1);
    vec(0, 0, 0, 0, 0, 0, 0, -1);

    // plain divide, issued alongside a load-use request
    vec(DS | ID, 0, 15, 0, 0, -1, -1, -1);
    vec(0, 0, 15, 0, 1, -1, -1, -1);
    vec(0, 0, 15, 0, 1, -1, -1, -1);
    vec(0, 0, 15, 0, 1, -1, -1, -1);
    vec(0, 0, 0, 1, 1, -1, -1, -1);
    vec(0, 0, 0, 0, 0, -1, -1, -1);

    // mem stall in the middle of a divide
    vec(DS, 0, 15, 0, 0, -1, -1, -1);
    vec(0, 0, 15, 0, 1, -1, -1, -1);
    vec(MEM, 0, 31, 0, 1, -1, -1, -1);
    vec(MEM, 0, 31, 0, 1, -1, -1, -1);
    vec(0, 0, 15, 0, 1, -1, -1, -1);
    vec(0, 0, 15, 0, 1, -1, -1, -1);
    vec(0, 0, 0, 1, 1, -1, -1, -1);
    vec(0, 0, 0, 0, 0, -1, -1, -1);

    // eret aborts a divide
    vec(DS, 0, 15, 0, 0, -1, -1, -1);
    vec(0, 0, 15, 0, 1, -1, -1, -1);
    vec(EXC | ERET, 32'h8000_1234, 0, 0, 1, 1, 64'h8000_1234, -1);
    vec(0, 32'h8000_1234, 0, 0, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) vec(0, 0, 0, 0, 0, -1, -1, -1);

    // refused issue under mem stall, held div_start, reset mid-divide
    vec(DS | MEM, 0, 31, 0, 0, -1, -1, -1);
    vec(DS, 0, 15, 0, 0, -1, -1, -1);
    vec(DS, 0, 15, 0, 1, -1, -1, -1);
    vec(DS, 0, 15, 0, 1, -1, -1, -1);
    vec(DS, 0, 15, 0, 1, -1, -1, -1);
    vec(DS, 0, 0, 1, 1, -1, -1, -1);
    vec(DS, 0, 15, 0, 0, -1, -1, -1);
    vec(RST | DS, 0, 0, 0, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0);

    // stall counter wrap
    force dut.stall_cnt = 32'hFFFF_FFFF;
    wrap_load = 1'b1;
    vec(0, 0, 0, -1, -1, -1, -1, 64'hFFFF_FFFF);
    release dut.stall_cnt;
    wrap_load = 1'b0;
    vec(IFR, 0, 3, -1, -1, -1, -1, 64'hFFFF_FFFF);
    vec(0, 0, 0, -1, -1, -1, -1, 0);
    vec(IFR, 0, 3, -1, -1, -1, -1, 0);
    vec(0, 0, 0, -1, -1, -1, -1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
